// File: rtl/logic_unit_pkg.sv
// Shared types and constants for the pipelined logical unit.
// Operation encoding, flag bit positions and default geometry.
package logic_unit_pkg;

    typedef enum logic [2:0] {
        LU_AND   = 3'd0,
        LU_OR    = 3'd1,
        LU_XOR   = 3'd2,
        LU_BIC   = 3'd3,
        LU_ORN   = 3'd4,
        LU_EON   = 3'd5,
        LU_PASSA = 3'd6,
        LU_PASSB = 3'd7
    } lu_op_t;

    // Bit positions inside the {N,Z,V,C} flag vector.
    localparam int LU_FLAG_N = 3;
    localparam int LU_FLAG_Z = 2;
    localparam int LU_FLAG_V = 1;
    localparam int LU_FLAG_C = 0;

    localparam int LU_DEF_WIDTH  = 64;
    localparam int LU_DEF_ZCHUNK = 16;

endpackage

// File: rtl/zero_chunk_detect.sv
// Partial zero detect: one bit per ZCHUNK-wide group of the input,
// set when that group is entirely zero.
module zero_chunk_detect
    import logic_unit_pkg::*;
#(
    parameter int WIDTH  = LU_DEF_WIDTH,
    parameter int ZCHUNK = LU_DEF_ZCHUNK
) (
    input  logic [WIDTH-1:0]        data_i,
    output logic [WIDTH/ZCHUNK-1:0] pz_o
);

    localparam int NZ = WIDTH / ZCHUNK;

    // One narrow NOR-reduction per group keeps stage 1 shallow.
    for (genvar g = 0; g < NZ; g++) begin : g_chunk
        assign pz_o[g] = ~|data_i[g*ZCHUNK +: ZCHUNK];
    end

endmodule

// File: rtl/logic_unit_pipe.sv
// Two-stage pipelined logical unit with valid/ready handshake,
// per-beat N/Z/V/C flags and an architectural NZCV register.
module logic_unit_pipe
    import logic_unit_pkg::*;
#(
    parameter int WIDTH  = LU_DEF_WIDTH,
    parameter int ZCHUNK = LU_DEF_ZCHUNK
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       op,
    input  logic             set_flags,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             negative,
    output logic             zero,
    output logic             overflow,
    output logic             carry_out,
    output logic [3:0]       flags_q
);

    localparam int NZ = WIDTH / ZCHUNK;

    if ((WIDTH % ZCHUNK) != 0 || WIDTH < ZCHUNK) begin : g_bad_geom
        $error("logic_unit_pipe: WIDTH must be a multiple of ZCHUNK");
    end

    logic [WIDTH-1:0] r1_d;
    logic [WIDTH-1:0] r1_q;
    logic [NZ-1:0]    pz1_d;
    logic [NZ-1:0]    pz1_q;
    logic             sf1_q;
    logic             s1_valid_q;

    logic [WIDTH-1:0] r2_q;
    logic             n2_q;
    logic             z2_q;
    logic             sf2_q;
    logic             s2_valid_q;

    logic             accept;
    logic             out_hs;
    logic             s1_adv;
    logic [3:0]       flags_d;

    assign out_hs   = s2_valid_q && out_ready;
    assign s1_adv   = !s2_valid_q || out_hs;
    assign in_ready = !s1_valid_q || s1_adv;
    assign accept   = in_valid && in_ready;

    // Operation select on the raw operands.
    always_comb begin
        r1_d = '0;
        unique case (lu_op_t'(op))
            LU_AND:   r1_d = a & b;
            LU_OR:    r1_d = a | b;
            LU_XOR:   r1_d = a ^ b;
            LU_BIC:   r1_d = a & ~b;
            LU_ORN:   r1_d = a | ~b;
            LU_EON:   r1_d = a ^ ~b;
            LU_PASSA: r1_d = a;
            LU_PASSB: r1_d = b;
        endcase
    end

    zero_chunk_detect #(
        .WIDTH  (WIDTH),
        .ZCHUNK (ZCHUNK)
    ) u_zdet (
        .data_i (r1_d),
        .pz_o   (pz1_d)
    );

    // Stage 1: capture the result and partial zero bits on accept.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            r1_q       <= '0;
            pz1_q      <= '0;
            sf1_q      <= 1'b0;
        end else if (in_ready) begin
            s1_valid_q <= in_valid;
            if (in_valid) begin
                r1_q  <= r1_d;
                pz1_q <= pz1_d;
                sf1_q <= set_flags;
            end
        end
    end

    // Stage 2: finish the zero reduction and hold while stalled.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2_valid_q <= 1'b0;
            r2_q       <= '0;
            n2_q       <= 1'b0;
            z2_q       <= 1'b0;
            sf2_q      <= 1'b0;
        end else if (s1_adv) begin
            s2_valid_q <= s1_valid_q;
            if (s1_valid_q) begin
                r2_q  <= r1_q;
                n2_q  <= r1_q[WIDTH-1];
                z2_q  <= &pz1_q;
                sf2_q <= sf1_q;
            end
        end
    end

    // Flags a beat would commit when it leaves the unit.
    always_comb begin
        flags_d            = '0;
        flags_d[LU_FLAG_N] = n2_q;
        flags_d[LU_FLAG_Z] = z2_q;
        flags_d[LU_FLAG_V] = 1'b0;
        flags_d[LU_FLAG_C] = 1'b0;
    end

    // Architectural NZCV: written only when a flag-setting beat retires.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags_q <= 4'b0000;
        end else if (out_hs && sf2_q) begin
            flags_q <= flags_d;
        end
    end

    assign out_valid = s2_valid_q;
    assign result    = r2_q;
    assign negative  = n2_q;
    assign zero      = z2_q;
    assign overflow  = 1'b0;
    assign carry_out = 1'b0;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Bench for logic_unit_pipe: queue-based reference model plus
// directed literal cases and a randomized streaming phase.
module tb_logic_unit_pipe;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  op = 3'd0;
    logic        set_flags = 1'b0;
    logic [63:0] a = '0;
    logic [63:0] b = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] result;
    logic        negative, zero, overflow, carry_out;
    logic [3:0]  flags_q;

    logic        in_valid2 = 1'b0;
    logic        in_ready2;
    logic [2:0]  op2 = 3'd0;
    logic [31:0] a2 = '0;
    logic [31:0] b2 = '0;
    logic        out_valid2;
    logic        out_ready2 = 1'b1;
    logic [31:0] result2;
    logic        negative2, zero2, overflow2, carry2;
    logic [3:0]  flags2;

    int checks = 0;
    int failures = 0;
    int hs_count = 0;

    always #5 clk = ~clk;

    logic_unit_pipe #(.WIDTH(64), .ZCHUNK(16)) dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .set_flags(set_flags), .a(a), .b(b),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .negative(negative), .zero(zero),
        .overflow(overflow), .carry_out(carry_out), .flags_q(flags_q)
    );

    logic_unit_pipe #(.WIDTH(32), .ZCHUNK(8)) dut32 (
        .clk(clk), .reset(reset),
        .in_valid(in_valid2), .in_ready(in_ready2),
        .op(op2), .set_flags(1'b0), .a(a2), .b(b2),
        .out_valid(out_valid2), .out_ready(out_ready2),
        .result(result2), .negative(negative2), .zero(zero2),
        .overflow(overflow2), .carry_out(carry2), .flags_q(flags2)
    );

    task automatic chk(input string name, input logic [63:0] got,
                       input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", name, got, exp);
        end
    endtask

    // Reference: the op table applied to plain operands.
    function automatic logic [63:0] ref_op(input logic [2:0] o,
                                           input logic [63:0] x,
                                           input logic [63:0] y);
        case (o)
            3'd0:    return x & y;
            3'd1:    return x | y;
            3'd2:    return x ^ y;
            3'd3:    return x & ~y;
            3'd4:    return x | ~y;
            3'd5:    return ~(x ^ y);
            3'd6:    return x;
            default: return y;
        endcase
    endfunction

    typedef struct {
        logic [63:0] r;
        logic        sf;
        int          age;
    } beat_t;

    beat_t       q[$];
    logic [3:0]  mflags = 4'b0;

    // Model: beats queue in order, surface two edges after accept,
    // leave on handshake; pipe holds at most two beats.
    always @(negedge clk) begin
        logic  exp_ov;
        logic  exp_ir;
        beat_t nb;
        if (!reset) begin
            q.delete();
            mflags = 4'b0;
            chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
            chk("rst_flags_q", {60'b0, flags_q}, 64'd0);
        end else begin
            foreach (q[i]) q[i].age++;
            exp_ov = (q.size() > 0) && (q[0].age >= 2);
            exp_ir = (q.size() < 2) || (exp_ov && out_ready);
            chk("out_valid", {63'b0, out_valid}, {63'b0, exp_ov});
            chk("in_ready", {63'b0, in_ready}, {63'b0, exp_ir});
            chk("flags_q", {60'b0, flags_q}, {60'b0, mflags});
            if (exp_ov) begin
                chk("result", result, q[0].r);
                chk("negative", {63'b0, negative}, {63'b0, q[0].r[63]});
                chk("zero", {63'b0, zero}, {63'b0, q[0].r == 64'd0});
                chk("overflow", {63'b0, overflow}, 64'd0);
                chk("carry_out", {63'b0, carry_out}, 64'd0);
                if (out_ready) begin
                    if (q[0].sf)
                        mflags = {q[0].r[63], q[0].r == 64'd0, 2'b00};
                    void'(q.pop_front());
                    hs_count++;
                end
            end
            if (in_valid && exp_ir) begin
                nb.r   = ref_op(op, a, b);
                nb.sf  = set_flags;
                nb.age = 0;
                q.push_back(nb);
            end
        end
    end

    task automatic send(input logic [2:0] o, input logic [63:0] x,
                        input logic [63:0] y, input logic sf);
        bit got = 0;
        op = o; a = x; b = y; set_flags = sf; in_valid = 1'b1;
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (in_ready) got = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        if (!got) chk("send_timeout", 64'd1, 64'd0);
    endtask

    // Counts edges from the accept edge until out_valid is seen.
    task automatic wait_out(output int n);
        bit seen = 0;
        n = 1;
        for (int i = 0; i < 30 && !seen; i++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
            else begin
                @(posedge clk); #1;
                n++;
            end
        end
        if (!seen) chk("wait_out_timeout", 64'd1, 64'd0);
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int n;
        int hs0;
        int sent;
        bit saw_stall;
        bit got2;
        logic [63:0] bp_a [5];

        cyc(3);
        reset = 1'b1;
        cyc(1);
        chk("reset_in_ready", {63'b0, in_ready}, 64'd1);
        chk("reset_result", result, 64'd0);

        // 32-bit instance, 8-bit zero groups.
        op2 = 3'd0; a2 = 32'h8000_0001; b2 = 32'h8000_0000;
        in_valid2 = 1'b1;
        cyc(1);
        in_valid2 = 1'b0;
        got2 = 0;
        for (int i = 0; i < 10 && !got2; i++) begin
            @(negedge clk);
            if (out_valid2) got2 = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        chk("w32_valid", {63'b0, got2}, 64'd1);
        chk("w32_result", {32'b0, result2}, 64'h8000_0000);
        chk("w32_n", {63'b0, negative2}, 64'd1);
        chk("w32_z", {63'b0, zero2}, 64'd0);
        cyc(1);

        out_ready = 1'b1;
        send(3'd1, 64'hF0, 64'h0F, 1'b0);
        wait_out(n);
        chk("or_latency", n, 64'd2);
        chk("or_result", result, 64'hFF);
        chk("or_nz", {62'b0, negative, zero}, 64'd0);
        cyc(1);

        send(3'd2, 64'hDEAD_BEEF_0123_4567, 64'hDEAD_BEEF_0123_4567, 1'b1);
        wait_out(n);
        chk("xor_result", result, 64'd0);
        chk("xor_zero", {63'b0, zero}, 64'd1);
        cyc(1);
        chk("xor_flags", {60'b0, flags_q}, 64'h4);

        send(3'd4, 64'd0, 64'd0, 1'b0);
        wait_out(n);
        chk("orn_result", result, {64{1'b1}});
        chk("orn_neg", {63'b0, negative}, 64'd1);
        cyc(1);
        send(3'd3, {64{1'b1}}, {64{1'b1}}, 1'b0);
        wait_out(n);
        chk("bic_zero", {63'b0, zero}, 64'd1);
        cyc(1);
        chk("nosf_flags", {60'b0, flags_q}, 64'h4);

        // Back-pressure: five beats, consumer stalls cycles 3..6.
        for (int i = 0; i < 5; i++) bp_a[i] = 64'h1000 + 64'(i);
        hs0 = hs_count;
        sent = 0;
        saw_stall = 0;
        for (int c = 0; c < 30; c++) begin
            out_ready = !(c >= 3 && c <= 6);
            in_valid  = (sent < 5);
            op = 3'd6; a = bp_a[sent < 5 ? sent : 4]; b = '0;
            set_flags = 1'b0;
            @(negedge clk);
            if (in_valid && in_ready) sent++;
            if (!in_ready) saw_stall = 1;
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("bp_stall_seen", {63'b0, saw_stall}, 64'd1);
        chk("bp_delivered", hs_count - hs0, 64'd5);

        // Reset with two beats in flight and N set in flags_q.
        send(3'd4, 64'd0, 64'd0, 1'b1);
        wait_out(n);
        cyc(1);
        chk("pre_rst_flags", {60'b0, flags_q}, 64'h8);
        out_ready = 1'b0;
        send(3'd1, 64'h1, 64'h2, 1'b1);
        send(3'd1, 64'h3, 64'h4, 1'b1);
        cyc(1);
        reset = 1'b0;
        #1;
        chk("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        chk("midrst_flags", {60'b0, flags_q}, 64'd0);
        cyc(2);
        reset = 1'b1;
        out_ready = 1'b1;
        cyc(1);
        send(3'd0, 64'hFFFF_0000_FFFF_0000, 64'hF0F0_F0F0_F0F0_F0F0, 1'b0);
        wait_out(n);
        chk("post_rst_latency", n, 64'd2);
        chk("post_rst_result", result, 64'hF0F0_0000_F0F0_0000);
        cyc(1);

        // Randomized stream against the model.
        for (int c = 0; c < 600; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 9) < 7);
            op        = 3'($urandom_range(0, 7));
            set_flags = 1'($urandom_range(0, 1));
            a         = {$urandom, $urandom};
            case ($urandom_range(0, 4))
                0: b = a;
                1: b = ~a;
                2: b = '0;
                default: b = {$urandom, $urandom};
            endcase
            if ($urandom_range(0, 7) == 0) a = '0;
            cyc(1);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        cyc(6);
        chk("drain_empty", q.size(), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
